// File: rtl/approx_add_arbiter_if.sv
// Request/response bundle for the shared approximate adder.
// The master side is the requester/consumer environment, the slave side is
// the arbiter itself. The operation counters ride along as slave outputs so
// monitors see them through the same handle.
interface approx_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0][31:0] req_a;
    logic [NUM_REQ-1:0][31:0] req_b;
    logic [NUM_REQ-1:0]       req_approx;
    logic [NUM_REQ-1:0]       req_ready;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [31:0]              resp_sum;
    logic                     resp_carry;
    logic                     resp_approx;

    logic [CNT_W-1:0]         exact_count;
    logic [CNT_W-1:0]         approx_count;

    modport master (
        output req_valid, req_a, req_b, req_approx, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_carry,
               resp_approx, exact_count, approx_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_approx, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_carry,
               resp_approx, exact_count, approx_count
    );
endinterface

// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder between NUM_REQ requesters.
// Each operation is either an exact add or an approximate add in which the
// low APPROX_LV bits are a plain OR with no carry leaving that region.
// A single response register carries the result downstream with valid/ready
// backpressure, and two saturating counters record how many operations of
// each mode were accepted.
module approx_add_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int APPROX_LV = 8,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    approx_add_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Width-matched copies of the requester count used by the scan wrap
    localparam logic [ID_W:0]   NUM_REQ_V  = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_REQ   = ID_W'(NUM_REQ - 1);

    // Bits covered by the OR approximation; 0 means none, 32 means all
    localparam logic [31:0] LOW_MASK = (APPROX_LV >= 32) ? 32'hFFFF_FFFF
                                     : ((32'd1 << APPROX_LV) - 32'd1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Architectural state
    logic [ID_W-1:0]  rrPtr_q,      rrPtr_d;
    logic             respValid_q,  respValid_d;
    logic [ID_W-1:0]  respId_q,     respId_d;
    logic [31:0]      respSum_q,    respSum_d;
    logic             respCarry_q,  respCarry_d;
    logic             respApprox_q, respApprox_d;
    logic [CNT_W-1:0] exactCnt_q,   exactCnt_d;
    logic [CNT_W-1:0] approxCnt_q,  approxCnt_d;

    // Arbitration and datapath intermediates
    logic             canAccept;
    logic             found;
    logic [ID_W-1:0]  grantIdx;
    logic [ID_W:0]    cand;
    logic             accept;
    logic [31:0]      selA;
    logic [31:0]      selB;
    logic             selApprox;
    logic [32:0]      exactSum;
    logic [32:0]      approxHigh;
    logic [31:0]      approxSum;
    logic             approxCarry;
    logic [31:0]      resultSum;
    logic             resultCarry;

    // The output slot is free when empty or being drained this cycle
    assign canAccept = !respValid_q || bus.resp_ready;

    // Round-robin scan: first valid requester at or after the pointer, with wrap
    always_comb begin
        found    = 1'b0;
        grantIdx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rrPtr_q} + k[ID_W:0];
            if (cand >= NUM_REQ_V) begin
                cand = cand - NUM_REQ_V;
            end
            if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
                found    = 1'b1;
                grantIdx = cand[ID_W-1:0];
            end
        end
    end

    // One-hot ready to the granted requester only; silenced while in reset
    always_comb begin
        bus.req_ready = '0;
        if (!reset && found && canAccept) begin
            bus.req_ready[grantIdx] = 1'b1;
        end
    end

    assign accept = !reset && found && canAccept;

    // Steer the granted requester's operands into the shared adder
    always_comb begin
        selA      = bus.req_a[grantIdx];
        selB      = bus.req_b[grantIdx];
        selApprox = bus.req_approx[grantIdx];
    end

    // Exact and approximate sums; the approximate upper part adds operands
    // with their low region zeroed, so no carry can leave the OR region
    always_comb begin
        exactSum    = {1'b0, selA} + {1'b0, selB};
        approxHigh  = {1'b0, selA & ~LOW_MASK} + {1'b0, selB & ~LOW_MASK};
        approxSum   = approxHigh[31:0] | ((selA | selB) & LOW_MASK);
        approxCarry = approxHigh[32];
        if (selApprox) begin
            resultSum   = approxSum;
            resultCarry = approxCarry;
        end else begin
            resultSum   = exactSum[31:0];
            resultCarry = exactSum[32];
        end
    end

    // Next state for pointer, response register and counters
    always_comb begin
        rrPtr_d      = rrPtr_q;
        respValid_d  = respValid_q;
        respId_d     = respId_q;
        respSum_d    = respSum_q;
        respCarry_d  = respCarry_q;
        respApprox_d = respApprox_q;
        exactCnt_d   = exactCnt_q;
        approxCnt_d  = approxCnt_q;

        if (accept) begin
            respValid_d  = 1'b1;
            respId_d     = grantIdx;
            respSum_d    = resultSum;
            respCarry_d  = resultCarry;
            respApprox_d = selApprox;
            rrPtr_d      = (grantIdx == LAST_REQ) ? '0 : grantIdx + ID_W'(1);
            if (selApprox) begin
                if (approxCnt_q != CNT_MAX) begin
                    approxCnt_d = approxCnt_q + CNT_W'(1);
                end
            end else begin
                if (exactCnt_q != CNT_MAX) begin
                    exactCnt_d = exactCnt_q + CNT_W'(1);
                end
            end
        end else if (bus.resp_ready) begin
            respValid_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously so a pending response vanishes at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rrPtr_q      <= '0;
            respValid_q  <= 1'b0;
            respId_q     <= '0;
            respSum_q    <= '0;
            respCarry_q  <= 1'b0;
            respApprox_q <= 1'b0;
            exactCnt_q   <= '0;
            approxCnt_q  <= '0;
        end else begin
            rrPtr_q      <= rrPtr_d;
            respValid_q  <= respValid_d;
            respId_q     <= respId_d;
            respSum_q    <= respSum_d;
            respCarry_q  <= respCarry_d;
            respApprox_q <= respApprox_d;
            exactCnt_q   <= exactCnt_d;
            approxCnt_q  <= approxCnt_d;
        end
    end

    assign bus.resp_valid   = respValid_q;
    assign bus.resp_id      = respId_q;
    assign bus.resp_sum     = respSum_q;
    assign bus.resp_carry   = respCarry_q;
    assign bus.resp_approx  = respApprox_q;
    assign bus.exact_count  = exactCnt_q;
    assign bus.approx_count = approxCnt_q;
endmodule

// File: tb/tb_approx_add_arbiter.sv
// Scoreboard bench for approx_add_arbiter: a bench-side round-robin and
// bit-serial adder model predicts each accept, queues the expected response
// and compares it against the response register while it is visible.
module tb_approx_add_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int APPROX_LV = 8;
    localparam int CNT_W     = 4;
    localparam int ID_W      = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     sum;
        logic            carry;
        logic            approx;
    } resp_t;

    logic clk;
    logic reset;

    int assertCount = 0;
    int failCount   = 0;

    resp_t            expQ[$];
    int               dutGrants[$];
    int               modelPtr;
    logic [CNT_W-1:0] modelExact;
    logic [CNT_W-1:0] modelApprox;

    approx_add_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus();

    approx_add_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .APPROX_LV (APPROX_LV),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Independent ripple model: OR below APPROX_LV with carry forced to 0
    function automatic logic [32:0] modelAdd(input logic [31:0] a, input logic [31:0] b,
                                             input logic approx);
        logic [31:0] s;
        logic        c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (approx && i < APPROX_LV) begin
                s[i] = a[i] | b[i];
                c    = 1'b0;
            end else begin
                s[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
        end
        return {c, s};
    endfunction

    // Drive one requester's request lines
    task automatic applyStimulus(input int r, input logic valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic approx);
        bus.req_valid[r]  = valid;
        bus.req_a[r]      = a;
        bus.req_b[r]      = b;
        bus.req_approx[r] = approx;
    endtask

    task automatic clearModel();
        expQ.delete();
        modelPtr    = 0;
        modelExact  = '0;
        modelApprox = '0;
    endtask

    // Assert reset, check the asynchronous clear, release on the next falling edge
    task automatic pulseReset();
        reset = 1'b1;
        #1;
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'(0));
        checkOutput("rst_exact_count", 64'(bus.exact_count), 64'(0));
        checkOutput("rst_approx_count", 64'(bus.approx_count), 64'(0));
        clearModel();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One cycle: compare visible response/counters, predict the grant, wait a cycle
    task automatic monitorCycle();
        resp_t           head;
        logic            canAcc;
        int              g;
        int              idx;
        logic [32:0]     res;
        logic [NUM_REQ-1:0] expReady;
        #2;
        canAcc = (expQ.size() == 0) || bus.resp_ready;
        checkOutput("resp_valid", 64'(bus.resp_valid), 64'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            head = expQ[0];
            checkOutput("resp_id", 64'(bus.resp_id), 64'(head.id));
            checkOutput("resp_sum", 64'(bus.resp_sum), 64'(head.sum));
            checkOutput("resp_carry", 64'(bus.resp_carry), 64'(head.carry));
            checkOutput("resp_approx", 64'(bus.resp_approx), 64'(head.approx));
            if (bus.resp_ready) begin
                void'(expQ.pop_front());
            end
        end
        checkOutput("exact_count", 64'(bus.exact_count), 64'(modelExact));
        checkOutput("approx_count", 64'(bus.approx_count), 64'(modelApprox));

        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (modelPtr + k) % NUM_REQ;
            if (g < 0 && bus.req_valid[idx]) g = idx;
        end
        expReady = '0;
        if (g >= 0 && canAcc) expReady[g] = 1'b1;
        checkOutput("req_ready", 64'(bus.req_ready), 64'(expReady));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i] && bus.req_valid[i]) dutGrants.push_back(i);
        end

        if (g >= 0 && canAcc) begin
            res         = modelAdd(bus.req_a[g], bus.req_b[g], bus.req_approx[g]);
            head.id     = ID_W'(g);
            head.sum    = res[31:0];
            head.carry  = res[32];
            head.approx = bus.req_approx[g];
            expQ.push_back(head);
            modelPtr = (g + 1) % NUM_REQ;
            if (bus.req_approx[g]) begin
                if (modelApprox != '1) modelApprox = modelApprox + 1'b1;
            end else begin
                if (modelExact != '1) modelExact = modelExact + 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic dropAll();
        for (int r = 0; r < NUM_REQ; r++) applyStimulus(r, 1'b0, '0, '0, 1'b0);
    endtask

    // Issue a single op from one requester, leave its response visible
    task automatic singleOp(input int r, input logic [31:0] a, input logic [31:0] b,
                            input logic approx);
        applyStimulus(r, 1'b1, a, b, approx);
        monitorCycle();
        applyStimulus(r, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        reset          = 1'b0;
        bus.resp_ready = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_approx = '0;
        clearModel();
        #1;
        $display("[TB] reset state");
        pulseReset();
        checkOutput("rst_resp_sum", 64'(bus.resp_sum), 64'(0));
        checkOutput("rst_resp_id", 64'(bus.resp_id), 64'(0));

        $display("[TB] exact and approximate adds");
        singleOp(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        checkOutput("t1_sum", 64'(bus.resp_sum), 64'h100);
        checkOutput("t1_exact_count", 64'(bus.exact_count), 64'(1));
        monitorCycle();
        singleOp(0, 32'h0000_00FF, 32'h0000_0001, 1'b1);
        checkOutput("t2_sum", 64'(bus.resp_sum), 64'hFF);
        checkOutput("t2_approx", 64'(bus.resp_approx), 64'(1));
        checkOutput("t2_approx_count", 64'(bus.approx_count), 64'(1));
        monitorCycle();
        singleOp(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        checkOutput("t3_sum", 64'(bus.resp_sum), 64'h0);
        checkOutput("t3_carry", 64'(bus.resp_carry), 64'(1));
        monitorCycle();
        singleOp(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        checkOutput("t4_sum", 64'(bus.resp_sum), 64'hFFFF_FFFF);
        checkOutput("t4_carry", 64'(bus.resp_carry), 64'(0));
        monitorCycle();
        monitorCycle();

        $display("[TB] round robin with all requesters valid");
        pulseReset();
        dutGrants.delete();
        for (int r = 0; r < NUM_REQ; r++) begin
            applyStimulus(r, 1'b1, 32'h1000_0000 * (r + 1) + 32'(r * 37),
                          32'h0F0F_00F0 + 32'(r * 3), r[0]);
        end
        for (int c = 0; c < 8; c++) monitorCycle();
        dropAll();
        monitorCycle();
        monitorCycle();
        checkOutput("rr_count", 64'(dutGrants.size()), 64'(8));
        for (int i = 0; i < 8 && i < dutGrants.size(); i++) begin
            checkOutput("rr_order", 64'(dutGrants[i]), 64'(i % NUM_REQ));
        end

        $display("[TB] backpressure hold and release");
        pulseReset();
        singleOp(0, 32'h1234_5678, 32'h0000_1111, 1'b0);
        bus.resp_ready = 1'b0;
        applyStimulus(1, 1'b1, 32'h0000_0F0F, 32'h0000_00F1, 1'b1);
        applyStimulus(2, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        for (int c = 0; c < 5; c++) monitorCycle();
        bus.resp_ready = 1'b1;
        monitorCycle();
        checkOutput("bp_valid_kept", 64'(bus.resp_valid), 64'(1));
        checkOutput("bp_next_id", 64'(bus.resp_id), 64'(1));
        applyStimulus(1, 1'b0, '0, '0, 1'b0);
        monitorCycle();
        applyStimulus(2, 1'b0, '0, '0, 1'b0);
        monitorCycle();
        monitorCycle();

        $display("[TB] counter saturation and reset mid-stream");
        pulseReset();
        applyStimulus(3, 1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0);
        for (int c = 0; c < 20; c++) monitorCycle();
        checkOutput("exact_sat", 64'(bus.exact_count), 64'(15));
        pulseReset();
        for (int c = 0; c < 3; c++) monitorCycle();
        dropAll();
        monitorCycle();
        monitorCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
